// File: rtl/lut_mask_cfg_loader.sv
// Loads byte-streamed LUT masks into the LUT bank, one slot per single-cycle write strobe.
// Define LUT_CFG_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK / ERR states).
module lut_mask_cfg_loader #(
    parameter int NUM_LUTS = 16,
    parameter int MASK_W   = 64,
    parameter int ADDR_W   = 4
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [MASK_W-1:0] cfg_mask,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int BYTES  = MASK_W / 8;
    localparam int BCNT_W = $clog2(BYTES + 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_LUTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [BCNT_W-1:0]   byte_cnt_reg;
    logic [ADDR_W-1:0]   slot_cnt_reg;
    logic [MASK_W-1:0]   shift_reg;
    logic [MASK_W-1:0]   shift_next;
    logic [ADDR_W-1:0]   cfg_addr_reg;
    logic [MASK_W-1:0]   cfg_mask_reg;
    logic                xfer;
    logic                can_start;
    logic                last_byte;
    logic                last_slot;
`ifdef LUT_CFG_CHECKSUM_EN
    logic [7:0]          checksum_reg;
`endif

    assign xfer      = s_valid && s_ready;
    assign can_start = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);
    assign last_byte = (byte_cnt_reg == LAST_BYTE);
    assign last_slot = (slot_cnt_reg == LAST_SLOT);

    // First byte of a slot ends up in the most-significant byte of the mask.
    generate
        if (MASK_W == 8) begin : g_byte_mask
            assign shift_next = s_data;
        end else begin : g_wide_mask
            assign shift_next = {shift_reg[MASK_W-9:0], s_data};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer && last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (last_slot) begin
`ifdef LUT_CFG_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = LOAD;
                end
            end
`ifdef LUT_CFG_CHECKSUM_EN
            CHECK: begin
                if (s_valid) begin
                    state_next = (s_data == checksum_reg) ? DONE : ERR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net) begin
        if (!blif_reset_net) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            slot_cnt_reg <= '0;
            shift_reg    <= '0;
            cfg_addr_reg <= '0;
            cfg_mask_reg <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
            checksum_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (can_start && start) begin
                slot_cnt_reg <= '0;
                byte_cnt_reg <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
                checksum_reg <= '0;
`endif
            end
            if ((state_reg == LOAD) && xfer) begin
                shift_reg    <= shift_next;
                byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
`ifdef LUT_CFG_CHECKSUM_EN
                checksum_reg <= checksum_reg ^ s_data;
`endif
                // Latch the write payload now so the strobe lands one cycle after the last byte.
                if (last_byte) begin
                    cfg_addr_reg <= slot_cnt_reg;
                    cfg_mask_reg <= shift_next;
                end
            end
            if ((state_reg == WRITE) && !last_slot) begin
                slot_cnt_reg <= slot_cnt_reg + ADDR_W'(1);
                byte_cnt_reg <= '0;
            end
        end
    end

    always_comb begin
        s_ready  = (state_reg == LOAD);
`ifdef LUT_CFG_CHECKSUM_EN
        s_ready  = s_ready || (state_reg == CHECK);
        cfg_err  = (state_reg == ERR);
`else
        cfg_err  = 1'b0;
`endif
        cfg_we   = (state_reg == WRITE);
        cfg_busy = (state_reg == LOAD) || (state_reg == WRITE) || (state_reg == CHECK);
        cfg_done = (state_reg == DONE);
        cfg_addr = cfg_addr_reg;
        cfg_mask = cfg_mask_reg;
    end

endmodule
